// File: rtl/shader_loader_pkg.sv
// Shared types for the shader slot loader: loader FSM state encoding.
package shader_loader_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      LOAD = 1'b1
   } load_state_e;

endpackage

// File: rtl/shader_slot_mem.sv
// Shader instruction store: one write port, NUM_FETCH independent registered read ports.
// Ports:
//   clk, rst_n         clock, async active-low reset (read registers only)
//   we, waddr, wdata   write port (full address = {slot, word})
//   rd_req             per-port read request
//   rd_addr            per-port full read address, packed NUM_FETCH x AW
//   rd_valid           per-port read valid, one cycle after rd_req
//   rd_data            per-port read data, holds when not valid
module shader_slot_mem #(
   parameter  int unsigned INSTR_WIDTH = 32,
   parameter  int unsigned DEPTH       = 512,
   parameter  int unsigned NUM_FETCH   = 4,
   localparam int unsigned AW          = $clog2(DEPTH)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             we,
   input  logic [AW-1:0]                    waddr,
   input  logic [INSTR_WIDTH-1:0]           wdata,
   input  logic [NUM_FETCH-1:0]             rd_req,
   input  logic [NUM_FETCH*AW-1:0]          rd_addr,
   output logic [NUM_FETCH-1:0]             rd_valid,
   output logic [NUM_FETCH*INSTR_WIDTH-1:0] rd_data
);

   logic [INSTR_WIDTH-1:0] mem [DEPTH];

   // Storage array is intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read ports; data holds its last value when a port is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= '0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_req;
         for (int unsigned i = 0; i < NUM_FETCH; i++) begin
            if (rd_req[i]) rd_data[i*INSTR_WIDTH +: INSTR_WIDTH] <= mem[rd_addr[i*AW +: AW]];
         end
      end
   end

endmodule

// File: rtl/shader_slot_loader.sv
// Double-buffered multi-port shader store: host bursts a program into an inactive
// slot, commits it as active, and NUM_FETCH fetch ports read the active slot.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   i_load_start/slot/len, i_load_abort load session control
//   i_host_valid/o_host_ready/i_host_wdata host word stream
//   o_load_busy/o_load_done/o_load_err  session status
//   i_commit/i_commit_slot, o_commit_rej, o_active_slot  slot activation
//   i_fetch_req/addr, o_fetch_valid/instr  per-port fetch (1-cycle latency)
module shader_slot_loader
   import shader_loader_pkg::*;
#(
   parameter  int unsigned INSTR_WIDTH = 32,
   parameter  int unsigned SLOT_DEPTH  = 256,
   parameter  int unsigned NUM_SLOTS   = 2,
   parameter  int unsigned NUM_FETCH   = 4,
   localparam int unsigned SLOT_AW     = $clog2(SLOT_DEPTH),
   localparam int unsigned SLOT_W      = $clog2(NUM_SLOTS)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_load_start,
   input  logic [SLOT_W-1:0]                i_load_slot,
   input  logic [SLOT_AW:0]                 i_load_len,
   input  logic                             i_load_abort,
   input  logic                             i_host_valid,
   output logic                             o_host_ready,
   input  logic [INSTR_WIDTH-1:0]           i_host_wdata,
   output logic                             o_load_busy,
   output logic                             o_load_done,
   output logic                             o_load_err,
   input  logic                             i_commit,
   input  logic [SLOT_W-1:0]                i_commit_slot,
   output logic                             o_commit_rej,
   output logic [SLOT_W-1:0]                o_active_slot,
   input  logic [NUM_FETCH-1:0]             i_fetch_req,
   input  logic [NUM_FETCH*SLOT_AW-1:0]     i_fetch_addr,
   output logic [NUM_FETCH-1:0]             o_fetch_valid,
   output logic [NUM_FETCH*INSTR_WIDTH-1:0] o_fetch_instr
);

   localparam int unsigned MEM_AW = SLOT_W + SLOT_AW;
   localparam logic [SLOT_AW:0] LEN_MAX = (SLOT_AW+1)'(SLOT_DEPTH);
   localparam logic [SLOT_AW:0] ONE     = (SLOT_AW+1)'(1);

   load_state_e           state_q, state_d;
   logic [SLOT_W-1:0]     slot_q, slot_d;
   logic [SLOT_AW:0]      len_q, len_d;
   logic [SLOT_AW:0]      count_q, count_d;
   logic                  err_q, err_d;
   logic                  done_q, done_d;
   logic                  busy_q;
   logic                  rej_q, rej_d;
   logic [SLOT_W-1:0]     active_q, active_d;
   logic                  start_legal;
   logic                  commit_hit;
   logic                  wr_en;
   logic [MEM_AW-1:0]     wr_addr;
   logic [NUM_FETCH*MEM_AW-1:0] rd_addr;

   // State and control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         slot_q   <= '0;
         len_q    <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         rej_q    <= 1'b0;
         active_q <= '0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         len_q    <= len_d;
         count_q  <= count_d;
         err_q    <= err_d;
         done_q   <= done_d;
         busy_q   <= (state_d == LOAD);
         rej_q    <= rej_d;
         active_q <= active_d;
      end
   end

   // Next-state, write strobe and commit decisions.
   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      len_d    = len_q;
      count_d  = count_q;
      err_d    = err_q;
      done_d   = 1'b0;
      wr_en    = 1'b0;
      start_legal = (i_load_slot != active_q) && (i_load_len != '0) && (i_load_len <= LEN_MAX);

      case (state_q)
         IDLE: begin
            if (i_load_start) begin
               if (start_legal) begin
                  slot_d  = i_load_slot;
                  len_d   = i_load_len;
                  count_d = '0;
                  err_d   = 1'b0;
                  state_d = LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            // Abort wins over a same-cycle word, which is dropped.
            if (i_load_abort) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (i_host_valid) begin
               wr_en   = 1'b1;
               count_d = count_q + ONE;
               if (count_q == len_q - ONE) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // The slot under load (including its final-word cycle) cannot be activated.
      commit_hit = (state_q == LOAD) && (i_commit_slot == slot_q);
      rej_d      = i_commit && commit_hit;
      active_d   = (i_commit && !commit_hit) ? i_commit_slot : active_q;
   end

   assign wr_addr = {slot_q, count_q[SLOT_AW-1:0]};

   // Fetch addresses use the active slot as it stands this cycle.
   always_comb begin
      rd_addr = '0;
      for (int unsigned i = 0; i < NUM_FETCH; i++) begin
         rd_addr[i*MEM_AW +: MEM_AW] = {active_q, i_fetch_addr[i*SLOT_AW +: SLOT_AW]};
      end
   end

   shader_slot_mem #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .DEPTH       (NUM_SLOTS * SLOT_DEPTH),
      .NUM_FETCH   (NUM_FETCH)
   ) u_mem (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wr_en),
      .waddr    (wr_addr),
      .wdata    (i_host_wdata),
      .rd_req   (i_fetch_req),
      .rd_addr  (rd_addr),
      .rd_valid (o_fetch_valid),
      .rd_data  (o_fetch_instr)
   );

   assign o_host_ready  = busy_q;
   assign o_load_busy   = busy_q;
   assign o_load_done   = done_q;
   assign o_load_err    = err_q;
   assign o_commit_rej  = rej_q;
   assign o_active_slot = active_q;

endmodule

// File: tb/tb_shader_slot_loader.sv
// Directed self-checking bench for shader_slot_loader (default parameters).
module tb_shader_slot_loader;

   logic         clk;
   logic         rst_n;
   logic         i_load_start;
   logic [0:0]   i_load_slot;
   logic [8:0]   i_load_len;
   logic         i_load_abort;
   logic         i_host_valid;
   logic         o_host_ready;
   logic [31:0]  i_host_wdata;
   logic         o_load_busy;
   logic         o_load_done;
   logic         o_load_err;
   logic         i_commit;
   logic [0:0]   i_commit_slot;
   logic         o_commit_rej;
   logic [0:0]   o_active_slot;
   logic [3:0]   i_fetch_req;
   logic [31:0]  i_fetch_addr;
   logic [3:0]   o_fetch_valid;
   logic [127:0] o_fetch_instr;

   int n_checks = 0;
   int n_fails  = 0;

   shader_slot_loader dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_load_start  (i_load_start),
      .i_load_slot   (i_load_slot),
      .i_load_len    (i_load_len),
      .i_load_abort  (i_load_abort),
      .i_host_valid  (i_host_valid),
      .o_host_ready  (o_host_ready),
      .i_host_wdata  (i_host_wdata),
      .o_load_busy   (o_load_busy),
      .o_load_done   (o_load_done),
      .o_load_err    (o_load_err),
      .i_commit      (i_commit),
      .i_commit_slot (i_commit_slot),
      .o_commit_rej  (o_commit_rej),
      .o_active_slot (o_active_slot),
      .i_fetch_req   (i_fetch_req),
      .i_fetch_addr  (i_fetch_addr),
      .o_fetch_valid (o_fetch_valid),
      .o_fetch_instr (o_fetch_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int p, input logic [7:0] a);
      i_fetch_addr[p*8 +: 8] = a;
   endtask

   function automatic logic [31:0] instr_of(input int p);
      return o_fetch_instr[p*32 +: 32];
   endfunction

   task automatic start(input logic [0:0] slot, input logic [8:0] len);
      i_load_start = 1'b1;
      i_load_slot  = slot;
      i_load_len   = len;
      tick();
      i_load_start = 1'b0;
   endtask

   initial begin
      int hs;
      int cyc;
      logic exp_done;

      rst_n = 1'b1;
      i_load_start = 0; i_load_slot = 0; i_load_len = 0; i_load_abort = 0;
      i_host_valid = 0; i_host_wdata = 0; i_commit = 0; i_commit_slot = 0;
      i_fetch_req = 0; i_fetch_addr = 0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", o_host_ready, 0);
      check("rst_busy", o_load_busy, 0);
      check("rst_done", o_load_done, 0);
      check("rst_err", o_load_err, 0);
      check("rst_rej", o_commit_rej, 0);
      check("rst_fvalid", o_fetch_valid, 0);
      check("rst_active", o_active_slot, 0);
      check("rst_finstr", o_fetch_instr[63:0], 0);
      rst_n = 1'b1;
      tick();

      // Start targeting the active slot is refused.
      start(1'b0, 9'd4);
      check("ill_active_err", o_load_err, 1);
      check("ill_active_busy", o_load_busy, 0);

      // Legal load of slot 1 with commits to the loading slot mid-burst and on the last word.
      start(1'b1, 9'd4);
      check("ld1_err_clr", o_load_err, 0);
      check("ld1_busy", o_load_busy, 1);
      check("ld1_ready", o_host_ready, 1);
      for (int k = 0; k < 4; k++) begin
         i_host_valid  = 1'b1;
         i_host_wdata  = 32'hA0 + 32'(k);
         i_commit      = (k == 1) || (k == 3);
         i_commit_slot = 1'b1;
         tick();
         check("ld1_rej", o_commit_rej, ((k == 1) || (k == 3)) ? 1 : 0);
         check("ld1_active", o_active_slot, 0);
         check("ld1_done", o_load_done, (k == 3) ? 1 : 0);
      end
      i_host_valid = 1'b0;
      i_commit = 1'b0;
      tick();
      check("ld1_done_once", o_load_done, 0);
      check("ld1_idle", o_load_busy, 0);
      check("ld1_rej_clr", o_commit_rej, 0);

      // Length out of range.
      start(1'b1, 9'd0);
      check("len0_err", o_load_err, 1);
      check("len0_busy", o_load_busy, 0);
      start(1'b1, 9'd257);
      check("len257_err", o_load_err, 1);
      check("len257_busy", o_load_busy, 0);

      // Activate slot 1 and read it.
      i_commit = 1'b1; i_commit_slot = 1'b1;
      tick();
      i_commit = 1'b0;
      check("cm1_active", o_active_slot, 1);
      check("cm1_rej", o_commit_rej, 0);
      i_fetch_req = 4'b0100;
      set_addr(2, 8'd3);
      tick();
      i_fetch_req = 4'b0000;
      check("f2_valid", o_fetch_valid, 4'b0100);
      check("f2_instr", instr_of(2), 32'hA3);
      tick();
      check("f2_valid_drop", o_fetch_valid, 0);
      check("f2_instr_hold", instr_of(2), 32'hA3);

      // Load slot 0 with valid toggling while all four ports read slot 1.
      start(1'b0, 9'd8);
      hs = 0;
      cyc = 0;
      while (hs < 8 && cyc < 40) begin
         check("t_ready", o_host_ready, 1);
         i_host_valid = (cyc % 2) == 0;
         i_host_wdata = 32'hB0 + 32'(hs);
         i_fetch_req  = 4'hF;
         for (int p = 0; p < 4; p++) set_addr(p, 8'((cyc + p) % 4));
         tick();
         exp_done = 1'b0;
         if (i_host_valid) begin
            hs++;
            exp_done = (hs == 8);
         end
         check("t_done", o_load_done, exp_done);
         check("t_fvalid", o_fetch_valid, 4'hF);
         for (int p = 0; p < 4; p++)
            check("t_finstr", instr_of(p), 32'hA0 + 32'((cyc + p) % 4));
         cyc++;
      end
      check("t_handshakes", hs, 8);
      i_host_valid = 1'b0;
      i_fetch_req = 4'h0;
      tick();
      check("t_done_clr", o_load_done, 0);

      // Commit slot 0 with a same-cycle fetch: fetch still sees slot 1.
      i_commit = 1'b1; i_commit_slot = 1'b0;
      i_fetch_req = 4'b0001;
      set_addr(0, 8'd3);
      tick();
      i_commit = 1'b0;
      check("cm0_active", o_active_slot, 0);
      check("cm0_old_slot", instr_of(0), 32'hA3);
      for (int b = 0; b < 2; b++) begin
         i_fetch_req = 4'hF;
         for (int p = 0; p < 4; p++) set_addr(p, 8'(b*4 + p));
         tick();
         for (int p = 0; p < 4; p++)
            check("s0_word", instr_of(p), 32'hB0 + 32'(b*4 + p));
      end
      i_fetch_req = 4'h0;

      // Abort after 2 of 5 words; the word offered with the abort is dropped.
      start(1'b1, 9'd5);
      for (int k = 0; k < 2; k++) begin
         i_host_valid = 1'b1;
         i_host_wdata = 32'hC0 + 32'(k);
         tick();
      end
      i_host_wdata = 32'hEE;
      i_load_abort = 1'b1;
      tick();
      i_load_abort = 1'b0;
      i_host_valid = 1'b0;
      check("ab_busy", o_load_busy, 0);
      check("ab_err", o_load_err, 1);
      check("ab_done", o_load_done, 0);
      tick();
      check("ab_done_late", o_load_done, 0);
      i_commit = 1'b1; i_commit_slot = 1'b1;
      tick();
      i_commit = 1'b0;
      check("ab_commit", o_active_slot, 1);
      i_fetch_req = 4'hF;
      for (int p = 0; p < 4; p++) set_addr(p, 8'(p));
      tick();
      i_fetch_req = 4'h0;
      check("ab_w0", instr_of(0), 32'hC0);
      check("ab_w1", instr_of(1), 32'hC1);
      check("ab_w2_kept", instr_of(2), 32'hA2);
      check("ab_w3_kept", instr_of(3), 32'hA3);

      // Next legal start clears the sticky error; single-word load.
      start(1'b0, 9'd1);
      check("clr_err", o_load_err, 0);
      check("clr_busy", o_load_busy, 1);
      i_host_valid = 1'b1;
      i_host_wdata = 32'hD0;
      tick();
      i_host_valid = 1'b0;
      check("len1_done", o_load_done, 1);
      check("len1_idle", o_load_busy, 0);

      // Reset mid-load returns to idle immediately.
      start(1'b0, 9'd4);
      i_host_valid = 1'b1;
      i_host_wdata = 32'hF0;
      tick();
      i_host_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mr_busy", o_load_busy, 0);
      check("mr_ready", o_host_ready, 0);
      check("mr_active", o_active_slot, 0);
      #1 rst_n = 1'b1;
      tick();
      check("mr_idle", o_load_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
